// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the I2S ADC capture path
package audio_pkg;

    // Bits kept per channel unless the instantiating block overrides it.
    localparam int AUDIO_SAMPLE_W = 16;

    // Word-select level that marks the left channel slot.
    localparam logic LRCLK_LEFT = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2
    } state_t;

endpackage

// File: rtl/i2s_adc_capture_if.sv
// rtl/i2s_adc_capture_if.sv - FIFO push port carrying completed stereo pairs
//
// fifo_din    packed {right, left} sample pair
// fifo_wr_en  one-cycle push strobe
// fifo_full   back-pressure from the FIFO; a push is suppressed while high
interface i2s_adc_capture_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] fifo_din;
    logic              fifo_wr_en;
    logic              fifo_full;

    modport master (
        output fifo_din,
        output fifo_wr_en,
        input  fifo_full
    );

    modport slave (
        input  fifo_din,
        input  fifo_wr_en,
        output fifo_full
    );
endinterface

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchronizer with rising-edge detect
//
// clk    sampling clock
// rst    synchronous active-high reset
// din    asynchronous input pin
// level  synchronized level (last synchronizer stage)
// rise   one-cycle pulse when level goes 0->1
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        level  = sync_q[STAGES-1];
        prev_d = level;
        rise   = level & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/i2s_adc_capture.sv
// rtl/i2s_adc_capture.sv - I2S ADC receiver producing 16-bit L/R pairs for a 32-bit FIFO
//
// bus_clk, rst                 single clock, synchronous active-high reset
// enable                       capture enable; low forces IDLE and clears frame_err
// audio_bclk/adc_lrclk/adc     asynchronous I2S pins from the codec
// left_data, right_data        last complete stereo pair
// sample_valid                 one-cycle pulse when a new pair is presented
// fifo                         push port: {right, left}, wr_en, full
// overflow_cnt                 saturating count of pairs dropped on fifo_full
// frame_err                    sticky: a channel slot carried fewer than SAMPLE_W bits
module i2s_adc_capture
    import audio_pkg::*;
#(
    parameter int SAMPLE_W    = AUDIO_SAMPLE_W,
    parameter int SYNC_STAGES = 2,
    parameter int OVF_CNT_W   = 8
) (
    input  logic                 bus_clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 audio_bclk,
    input  logic                 audio_adc_lrclk,
    input  logic                 audio_adc,
    output logic [SAMPLE_W-1:0]  left_data,
    output logic [SAMPLE_W-1:0]  right_data,
    output logic                 sample_valid,
    i2s_adc_capture_if.master    fifo,
    output logic [OVF_CNT_W-1:0] overflow_cnt,
    output logic                 frame_err
);

    localparam int                CNT_W    = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SAMPLE_W - 1);

    logic bclk_rise, lr_lvl, adc_lvl;
    logic unused_bclk_lvl, unused_lr_rise, unused_adc_rise;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(bus_clk), .rst(rst), .din(audio_bclk),
        .level(unused_bclk_lvl), .rise(bclk_rise)
    );
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk(bus_clk), .rst(rst), .din(audio_adc_lrclk),
        .level(lr_lvl), .rise(unused_lr_rise)
    );
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_adc (
        .clk(bus_clk), .rst(rst), .din(audio_adc),
        .level(adc_lvl), .rise(unused_adc_rise)
    );

    state_t                state_q, state_d;
    logic                  lr_prev_q, lr_prev_d;
    logic [CNT_W-1:0]      nbits_q, nbits_d;
    logic [SAMPLE_W-1:0]   shift_q, shift_d;
    logic [SAMPLE_W-1:0]   lhold_q, lhold_d;
    logic [SAMPLE_W-1:0]   rhold_q, rhold_d;
    logic                  left_ok_q, left_ok_d;
    logic                  pend_q, pend_d;
    logic [SAMPLE_W-1:0]   left_q, left_d;
    logic [SAMPLE_W-1:0]   right_q, right_d;
    logic                  valid_q, valid_d;
    logic [OVF_CNT_W-1:0]  ovf_q, ovf_d;
    logic                  ferr_q, ferr_d;

    logic                  lr_chg;
    logic                  word_full;
    logic [SAMPLE_W-1:0]   word_done;

    always_comb begin
        state_d   = state_q;
        lr_prev_d = lr_prev_q;
        nbits_d   = nbits_q;
        shift_d   = shift_q;
        lhold_d   = lhold_q;
        rhold_d   = rhold_q;
        left_ok_d = left_ok_q;
        pend_d    = 1'b0;
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;
        ferr_d    = ferr_q;

        lr_chg    = bclk_rise && (lr_lvl != lr_prev_q);
        // A slot that already holds SAMPLE_W-1 bits takes its LSB from the
        // lr_chg strobe itself (exact-length slots with the I2S one-bit delay).
        word_full = (nbits_q == FULL_CNT) || (nbits_q == LAST_CNT);
        word_done = (nbits_q == FULL_CNT) ? shift_q
                                          : {shift_q[SAMPLE_W-2:0], adc_lvl};

        // Present the pair one cycle after the completing strobe.
        if (pend_q) begin
            left_d  = lhold_q;
            right_d = rhold_q;
            valid_d = 1'b1;
        end

        if (valid_q && fifo.fifo_full && (ovf_q != '1)) begin
            ovf_d = ovf_q + OVF_CNT_W'(1);
        end

        if (bclk_rise) begin
            lr_prev_d = lr_lvl;
            if (lr_chg) begin
                nbits_d = '0;
                shift_d = '0;
                unique case (state_q)
                    S_IDLE: begin
                        if (lr_lvl == LRCLK_LEFT) begin
                            state_d = S_LEFT;
                        end
                    end
                    S_LEFT: begin
                        lhold_d   = word_done;
                        left_ok_d = word_full;
                        if (!word_full) begin
                            ferr_d = 1'b1;
                        end
                        state_d = S_RIGHT;
                    end
                    S_RIGHT: begin
                        if (!word_full) begin
                            ferr_d = 1'b1;
                        end else if (left_ok_q) begin
                            rhold_d = word_done;
                            pend_d  = 1'b1;
                        end
                        state_d = S_LEFT;
                    end
                    default: state_d = S_IDLE;
                endcase
            end else if ((state_q != S_IDLE) && (nbits_q != FULL_CNT)) begin
                shift_d = {shift_q[SAMPLE_W-2:0], adc_lvl};
                nbits_d = nbits_q + CNT_W'(1);
            end
        end

        // Disable overrides everything, including a pair completing this cycle.
        if (!enable) begin
            state_d   = S_IDLE;
            nbits_d   = '0;
            shift_d   = '0;
            left_ok_d = 1'b0;
            pend_d    = 1'b0;
            valid_d   = 1'b0;
            left_d    = left_q;
            right_d   = right_q;
            ferr_d    = 1'b0;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lr_prev_q <= 1'b0;
            nbits_q   <= '0;
            shift_q   <= '0;
            lhold_q   <= '0;
            rhold_q   <= '0;
            left_ok_q <= 1'b0;
            pend_q    <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lr_prev_q <= lr_prev_d;
            nbits_q   <= nbits_d;
            shift_q   <= shift_d;
            lhold_q   <= lhold_d;
            rhold_q   <= rhold_d;
            left_ok_q <= left_ok_d;
            pend_q    <= pend_d;
            left_q    <= left_d;
            right_q   <= right_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            ferr_q    <= ferr_d;
        end
    end

    assign left_data       = left_q;
    assign right_data      = right_q;
    assign sample_valid    = valid_q;
    assign overflow_cnt    = ovf_q;
    assign frame_err       = ferr_q;
    assign fifo.fifo_din   = {right_q, left_q};
    assign fifo.fifo_wr_en = valid_q & ~fifo.fifo_full;

endmodule

// File: tb/tb_i2s_adc_capture.sv
// tb/tb_i2s_adc_capture.sv - scoreboard bench for i2s_adc_capture
module tb_i2s_adc_capture;

    logic        bus_clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        audio_bclk;
    logic        audio_adc_lrclk;
    logic        audio_adc;
    logic [15:0] left_data;
    logic [15:0] right_data;
    logic        sample_valid;
    logic [7:0]  overflow_cnt;
    logic        frame_err;

    i2s_adc_capture_if #(.DATA_W(32)) fifo_if ();

    i2s_adc_capture dut (
        .bus_clk         (bus_clk),
        .rst             (rst),
        .enable          (enable),
        .audio_bclk      (audio_bclk),
        .audio_adc_lrclk (audio_adc_lrclk),
        .audio_adc       (audio_adc),
        .left_data       (left_data),
        .right_data      (right_data),
        .sample_valid    (sample_valid),
        .fifo            (fifo_if),
        .overflow_cnt    (overflow_cnt),
        .frame_err       (frame_err)
    );

    always #5 bus_clk = ~bus_clk;

    typedef struct {
        logic [31:0] din;
        logic        wr;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Slot-level reference model state.
    int          bhalf = 40;
    bit          m_armed;
    int          m_ovf;
    bit          m_err;
    bit          m_last_c;
    int          m_len  [0:1];
    logic [15:0] m_word [0:1];
    logic        d_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_left_data"},    32'(left_data),    32'h0);
        check({tag, "_right_data"},   32'(right_data),   32'h0);
        check({tag, "_sample_valid"}, 32'(sample_valid), 32'h0);
        check({tag, "_fifo_wr_en"},   32'(fifo_if.fifo_wr_en), 32'h0);
        check({tag, "_fifo_din"},     fifo_if.fifo_din,  32'h0);
        check({tag, "_overflow_cnt"}, 32'(overflow_cnt), 32'h0);
        check({tag, "_frame_err"},    32'(frame_err),    32'h0);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_overflow_cnt"}, 32'(overflow_cnt), 32'(m_ovf));
        check({tag, "_frame_err"},    32'(frame_err),    32'(m_err));
    endtask

    // One channel slot of n bit clocks. Data lags word select by one bit
    // clock; the first 16 data bits are the word MSB-first, the rest padding.
    task automatic send_slot(input bit c, input int n, input logic [15:0] w);
        if (c == 1'b0 && m_last_c == 1'b1) begin
            if (enable) begin
                if (m_armed && m_len[0] >= 16 && m_len[1] >= 16) begin
                    exp_q.push_back('{din: {m_word[1], m_word[0]}, wr: !fifo_if.fifo_full});
                    if (fifo_if.fifo_full && m_ovf < 255) m_ovf++;
                end else if (m_armed) begin
                    m_err = 1'b1;
                end
            end
            m_armed = enable;
        end
        if (!enable) m_err = 1'b0;
        m_last_c  = c;
        m_len[c]  = n;
        m_word[c] = w;
        for (int j = 0; j < n; j++) begin
            audio_adc_lrclk = c;
            audio_adc       = d_prev;
            d_prev          = (j < 16) ? w[15-j] : 1'($urandom);
            #(bhalf) audio_bclk = 1'b1;
            #(bhalf) audio_bclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl, input int nr);
        send_slot(1'b0, nl, l);
        send_slot(1'b1, nr, r);
    endtask

    // Monitor: pops one expectation per presented pair.
    initial begin
        exp_t e;
        forever begin
            @(negedge bus_clk);
            if (sample_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("pairs_expected_pending", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("fifo_din",   fifo_if.fifo_din,            e.din);
                    check("left_data",  32'(left_data),              32'(e.din[15:0]));
                    check("right_data", 32'(right_data),             32'(e.din[31:16]));
                    check("fifo_wr_en", 32'(fifo_if.fifo_wr_en),     32'(e.wr));
                end
            end else if (fifo_if.fifo_wr_en === 1'b1) begin
                check("wr_en_without_valid", 32'(fifo_if.fifo_wr_en), 32'h0);
            end
        end
    end

    initial begin
        rst               = 1'b1;
        enable            = 1'b0;
        audio_bclk        = 1'b0;
        audio_adc_lrclk   = 1'b0;
        audio_adc         = 1'b0;
        fifo_if.fifo_full = 1'b0;
        m_armed = 1'b0; m_ovf = 0; m_err = 1'b0; m_last_c = 1'b0; d_prev = 1'b0;
        m_len[0] = 0; m_len[1] = 0; m_word[0] = '0; m_word[1] = '0;

        repeat (4) @(posedge bus_clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Enable rises partway through a left slot: that frame is discarded.
        send_slot(1'b1, 32, 16'($urandom));
        fork
            begin
                #(bhalf * 2 * 10);
                enable = 1'b1;
            end
        join_none
        send_slot(1'b0, 32, 16'($urandom));
        send_slot(1'b1, 32, 16'($urandom));

        // 32-bit slots with the reference pair, then random pairs.
        send_frame(16'hA5C3, 16'h1234, 32, 32);
        for (int i = 0; i < 4; i++) send_frame(16'($urandom), 16'($urandom), 32, 32);

        // Exact 16-bit slots: the LSB arrives on the word-select change.
        send_frame(16'h8001, 16'h7FFE, 16, 16);
        send_frame(16'($urandom), 16'($urandom), 16, 16);
        send_frame(16'($urandom), 16'($urandom), 32, 16);
        check_status("after_exact");

        // Short 12-bit left slot: pair dropped, frame_err sticks, capture continues.
        send_frame(16'($urandom), 16'($urandom), 12, 32);
        for (int i = 0; i < 3; i++) send_frame(16'($urandom), 16'($urandom), 32, 32);
        check_status("after_short");

        // FIFO full across three completions.
        fifo_if.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(16'($urandom), 16'($urandom), 32, 32);
        fifo_if.fifo_full = 1'b0;
        for (int i = 0; i < 2; i++) send_frame(16'($urandom), 16'($urandom), 32, 32);
        check_status("after_full3");

        // Long full stretch at a faster bit clock drives the counter to saturation.
        bhalf = 20;
        fifo_if.fifo_full = 1'b1;
        for (int i = 0; i < 300; i++) send_frame(16'($urandom), 16'($urandom), 16, 16);
        fifo_if.fifo_full = 1'b0;
        for (int i = 0; i < 2; i++) send_frame(16'($urandom), 16'($urandom), 16, 16);
        check_status("after_saturate");

        // Reset in the middle of a right slot.
        bhalf = 40;
        send_slot(1'b0, 32, 16'($urandom));
        fork
            begin
                #(bhalf * 2 * 12);
                rst = 1'b1;
                @(posedge bus_clk);
                #1;
                m_armed = 1'b0;
                m_ovf   = 0;
                m_err   = 1'b0;
                check_zero("rst_mid");
                rst = 1'b0;
            end
        join_none
        send_slot(1'b1, 32, 16'($urandom));
        for (int i = 0; i < 3; i++) send_frame(16'($urandom), 16'($urandom), 32, 32);

        // Opening edge of one more left slot completes the final pair.
        send_slot(1'b0, 8, 16'($urandom));
        repeat (20) @(posedge bus_clk);
        #1;
        check("expectations_left", 32'(exp_q.size()), 32'd0);
        check_status("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
